// File: rtl/cacheline_adaptor_if.sv
// cacheline_adaptor_if
//   Bundles the cache-side line port and the memory-side burst port of the
//   cacheline adaptor into one interface.
//
//   Cache side:
//     address_i  byte address of the requested line
//     read_i     line fill request
//     write_i    line writeback request
//     line_i     line to write back
//     line_o     filled line
//     resp_o     one-cycle completion pulse back to the cache
//   Memory side:
//     address_o  line-aligned memory address
//     read_o     memory read request
//     write_o    memory write request
//     burst_o    outgoing write beat
//     burst_i    incoming read beat
//     resp_i     beat accept/valid strobe from memory
//
//   Modports:
//     slave   the adaptor's view (requests come in, bursts go out)
//     master  the environment's view (cache + memory driving the adaptor)
interface cacheline_adaptor_if #(
  parameter int s_offset = 5,
  parameter int s_burst  = 64
);
  localparam int s_line = 8 * (2 ** s_offset);

  logic [31:0]         address_i;
  logic                read_i;
  logic                write_i;
  logic [s_line-1:0]   line_i;
  logic [s_line-1:0]   line_o;
  logic                resp_o;
  logic [31:0]         address_o;
  logic                read_o;
  logic                write_o;
  logic [s_burst-1:0]  burst_o;
  logic [s_burst-1:0]  burst_i;
  logic                resp_i;

  modport slave (
    input  address_i, read_i, write_i, line_i, burst_i, resp_i,
    output line_o, resp_o, address_o, read_o, write_o, burst_o
  );

  modport master (
    output address_i, read_i, write_i, line_i, burst_i, resp_i,
    input  line_o, resp_o, address_o, read_o, write_o, burst_o
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor
//   Converts between whole-line transfers on the cache side and multi-beat
//   bursts on the memory side. A fill gathers N beats into one line; a
//   writeback splits a saved line into N beats, lowest bits first.
//
//   Ports:
//     clk   clock, all state changes on the rising edge
//     rst   synchronous active-high reset, aborts any transfer in progress
//     bus   cacheline_adaptor_if.slave carrying the cache and memory signals
module cacheline_adaptor #(
  parameter int s_offset = 5,
  parameter int s_burst  = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  cacheline_adaptor_if.slave   bus
);

  localparam int s_line  = 8 * (2 ** s_offset);
  localparam int n_beats = s_line / s_burst;
  localparam int k_w     = (n_beats > 1) ? $clog2(n_beats) : 1;
  localparam logic [k_w-1:0] last_beat = k_w'(n_beats - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WB,
    DONE
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [k_w-1:0]     k;
  logic [s_line-1:0]  line_buf;
  logic [s_line-1:0]  saved_line;
  logic [31:0]        addr_reg;
  logic [31:0]        aligned_addr;
  logic               beat_last;

  assign aligned_addr = {bus.address_i[31:s_offset], {s_offset{1'b0}}};
  assign beat_last    = bus.resp_i && (k == last_beat);

  // State register. Reset returns to IDLE from anywhere, dropping the
  // transfer without ever raising resp_o.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs. Requests are only looked at in IDLE,
  // so a request still held high during DONE cannot start a second transfer;
  // it is picked up again only from the IDLE cycle that follows. Writeback
  // takes priority over fill when both are asserted together.
  always_comb begin
    state_next  = state;
    bus.read_o  = 1'b0;
    bus.write_o = 1'b0;
    bus.resp_o  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.write_i) begin
          state_next = WB;
        end else if (bus.read_i) begin
          state_next = FILL;
        end
      end
      FILL: begin
        bus.read_o = 1'b1;
        if (beat_last) begin
          state_next = DONE;
        end
      end
      WB: begin
        bus.write_o = 1'b1;
        if (beat_last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        bus.resp_o = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: address capture, beat counter, fill buffer and writeback copy.
  // The beat counter only moves on an accepted beat and holds at the last
  // index until DONE clears it, so it never wraps by itself. The fill buffer
  // doubles as line_o, and a writeback never touches it, so line_o keeps the
  // most recent fill across writebacks.
  always_ff @(posedge clk) begin
    if (rst) begin
      k          <= '0;
      line_buf   <= '0;
      saved_line <= '0;
      addr_reg   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          k <= '0;
          if (bus.write_i) begin
            saved_line <= bus.line_i;
            addr_reg   <= aligned_addr;
          end else if (bus.read_i) begin
            addr_reg   <= aligned_addr;
          end
        end
        FILL: begin
          if (bus.resp_i) begin
            line_buf[s_burst*int'(k) +: s_burst] <= bus.burst_i;
            if (k != last_beat) begin
              k <= k + 1'b1;
            end
          end
        end
        WB: begin
          if (bus.resp_i && (k != last_beat)) begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          k <= '0;
        end
        default: begin
          k <= '0;
        end
      endcase
    end
  end

  // The outgoing beat is always the slice of the saved line selected by the
  // beat counter; saved_line resets to zero, so burst_o does too.
  assign bus.address_o = addr_reg;
  assign bus.line_o    = line_buf;
  assign bus.burst_o   = saved_line[s_burst*int'(k) +: s_burst];

endmodule
